// File: rtl/baud_gen_pkg.sv
// Shared constants for the multi-channel baud generator: register map and defaults.
// Optional fractional divider is enabled by defining BAUD_GEN_FRAC_EN.
package baud_gen_pkg;

    localparam logic [1:0] ADDR_CTRL  = 2'b00;
    localparam logic [1:0] ADDR_FRAC  = 2'b01;
    localparam logic [1:0] ADDR_DIVLO = 2'b10;
    localparam logic [1:0] ADDR_DIVHI = 2'b11;

    localparam int unsigned DEF_DIV_W = 16;
    localparam int unsigned DEF_OSR   = 16;

endpackage

// File: rtl/baud_gen_ch.sv
// Single baud channel: divisor, down-counter, oversample phase and optional fraction.
// Define BAUD_GEN_FRAC_EN to add the 4-bit fractional accumulator (mean period D+F/16).
module baud_gen_ch
    import baud_gen_pkg::*;
#(
    parameter int unsigned DIV_W   = DEF_DIV_W,
    parameter int unsigned OSR     = DEF_OSR,
    parameter logic [15:0] RST_DIV = 16'd325
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [1:0]       ioaddr,
    input  logic [7:0]       wdata,
    output logic             sample_tick,
    output logic             bit_tick
);

    localparam int unsigned PH_W = $clog2(OSR);

    logic             en;
    logic [7:0]       div_lo;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic [PH_W-1:0]  phase;

    logic [DIV_W-1:0] new_div;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] new_eff;
    logic [DIV_W-1:0] tick_load;
    logic             wr_ctrl;
    logic             wr_lo;
    logic             wr_hi;
    logic             restart;

`ifdef BAUD_GEN_FRAC_EN
    logic [3:0] frac_stage;
    logic [3:0] frac_act;
    logic [3:0] acc;
    logic [4:0] acc_sum;
    logic       wr_frac;
`endif

    // Write decode, effective divisors (0/1 collapse to 1) and post-tick reload value
    always_comb begin
        wr_ctrl   = wr && (ioaddr == ADDR_CTRL);
        wr_lo     = wr && (ioaddr == ADDR_DIVLO);
        wr_hi     = wr && (ioaddr == ADDR_DIVHI);
        restart   = wr_ctrl && wdata[1];
        new_div   = DIV_W'({wdata, div_lo});
        div_eff   = (div[DIV_W-1:1] != '0) ? div : DIV_W'(1);
        new_eff   = (new_div[DIV_W-1:1] != '0) ? new_div : DIV_W'(1);
`ifdef BAUD_GEN_FRAC_EN
        wr_frac   = wr && (ioaddr == ADDR_FRAC);
        acc_sum   = {1'b0, acc} + {1'b0, frac_act};
        tick_load = acc_sum[4] ? div_eff : (div_eff - DIV_W'(1));
`else
        tick_load = div_eff - DIV_W'(1);
`endif
    end

    // Register writes, counter/phase sequencing and registered tick outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            en          <= 1'b0;
            div_lo      <= 8'd0;
            div         <= DIV_W'(RST_DIV);
            cnt         <= '0;
            phase       <= '0;
            sample_tick <= 1'b0;
            bit_tick    <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            frac_stage  <= 4'd0;
            frac_act    <= 4'd0;
            acc         <= 4'd0;
`endif
        end else begin
            sample_tick <= 1'b0;
            bit_tick    <= 1'b0;
            if (wr_ctrl) en     <= wdata[0];
            if (wr_lo)   div_lo <= wdata;
            if (wr_hi)   div    <= new_div;
`ifdef BAUD_GEN_FRAC_EN
            if (wr_frac) frac_stage <= wdata[3:0];
            if (wr_hi)   frac_act   <= frac_stage;
`endif
            // Writes take priority over a terminal count so no tick escapes a reload
            if (wr_hi) begin
                cnt <= new_eff - DIV_W'(1);
`ifdef BAUD_GEN_FRAC_EN
                acc <= frac_stage;
`endif
            end else if (restart || !en) begin
                cnt   <= div_eff - DIV_W'(1);
                phase <= '0;
`ifdef BAUD_GEN_FRAC_EN
                acc   <= frac_act;
`endif
            end else if (cnt == '0) begin
                sample_tick <= 1'b1;
                cnt         <= tick_load;
`ifdef BAUD_GEN_FRAC_EN
                acc         <= acc_sum[3:0];
`endif
                if (phase == PH_W'(OSR - 1)) begin
                    bit_tick <= 1'b1;
                    phase    <= '0;
                end else begin
                    phase <= phase + PH_W'(1);
                end
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/baud_gen_mc.sv
// Multi-channel baud generator top: decodes register writes and fans out to channels.
// Define BAUD_GEN_FRAC_EN to enable the per-channel fractional divider (FRAC register).
module baud_gen_mc
    import baud_gen_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DIV_W   = DEF_DIV_W,
    parameter int unsigned OSR     = DEF_OSR,
    parameter logic [15:0] RST_DIV = 16'd325
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        iocs,
    input  logic                                        iowr,
    input  logic [1:0]                                  ioaddr,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    input  logic [7:0]                                  wdata,
    output logic [NUM_CH-1:0]                           sample_tick,
    output logic [NUM_CH-1:0]                           bit_tick
);

    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic wr_ok;

    // A write is valid only when selected, strobed and aimed at an existing channel
    always_comb begin
        wr_ok = iocs && iowr && (32'(ch_sel) < NUM_CH);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_wr;

        // Route the write to this channel only
        always_comb begin
            ch_wr = wr_ok && (ch_sel == SEL_W'(i));
        end

        baud_gen_ch #(
            .DIV_W   (DIV_W),
            .OSR     (OSR),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .wr          (ch_wr),
            .ioaddr      (ioaddr),
            .wdata       (wdata),
            .sample_tick (sample_tick[i]),
            .bit_tick    (bit_tick[i])
        );
    end

endmodule

// File: tb/tb_baud_gen_mc.sv
// Directed self-checking bench for baud_gen_mc (default NUM_CH=2, DIV_W=16, OSR=16, RST_DIV=325).
// Expected values follow BAUD_GEN_FRAC_EN when it is defined for the build.
module tb_baud_gen_mc;
    import baud_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs;
    logic       iowr;
    logic [1:0] ioaddr;
    logic [0:0] ch_sel;
    logic [7:0] wdata;
    logic [1:0] sample_tick;
    logic [1:0] bit_tick;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int tc0    = 0;
    int tc1    = 0;

    baud_gen_mc dut (
        .clk         (clk),
        .rst         (rst),
        .iocs        (iocs),
        .iowr        (iowr),
        .ioaddr      (ioaddr),
        .ch_sel      (ch_sel),
        .wdata       (wdata),
        .sample_tick (sample_tick),
        .bit_tick    (bit_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sample_tick[0]) tc0 = tc0 + 1;
        if (sample_tick[1]) tc1 = tc1 + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wr(input logic ch, input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iowr = 1'b1; ch_sel = ch; ioaddr = a; wdata = d;
        @(posedge clk); #1;
        iocs = 1'b0; iowr = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!sample_tick[ch] && n < budget);
        if (!sample_tick[ch]) n = -1;
    endtask

    task automatic wait_bit(input int ch, input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bit_tick[ch] && n < budget);
        if (!bit_tick[ch]) n = -1;
    endtask

    initial begin
        int n;
        int k;
        int e0;
        int e1;
        int s0;
        int s1;

        rst = 1'b1; iocs = 1'b0; iowr = 1'b0; ioaddr = 2'b00; ch_sel = 1'b0; wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sample_tick", int'(sample_tick), 0);
        check("reset_bit_tick", int'(bit_tick), 0);
        rst = 1'b0;

        // ch0 at reset divisor 325
        wr(1'b0, ADDR_CTRL, 8'h01);
        e0 = cyc;
        wait_tick(0, 400, n);
        check("ch0_first_period", n, 325);
        wait_tick(0, 400, n);
        check("ch0_second_period", n, 325);
        wait_bit(0, 6000, n);
        check("ch0_bit_tick_at", (n < 0) ? -1 : cyc - e0, 5200);
        check("ch0_bit_with_sample", int'(sample_tick[0]), 1);

        // ch1 divisor 5
        wr(1'b1, ADDR_DIVLO, 8'h05);
        wr(1'b1, ADDR_DIVHI, 8'h00);
        wr(1'b1, ADDR_CTRL, 8'h01);
        for (int i = 0; i < 3; i++) begin
            wait_tick(1, 20, n);
            check("ch1_div5_period", n, 5);
        end
        wait_tick(0, 400, n);
        check("ch0_phase_kept", (n < 0) ? -1 : (cyc - e0) % 325, 0);

        // ch1 divisor 0 -> tick every cycle, bit every 16
        wr(1'b1, ADDR_DIVLO, 8'h00);
        wr(1'b1, ADDR_DIVHI, 8'h00);
        k = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (sample_tick[1]) k++;
        end
        check("ch1_div0_every_cycle", k, 16);
        wr(1'b1, ADDR_CTRL, 8'h03);
        wait_bit(1, 40, n);
        check("ch1_div0_bit_first", n, 16);
        wait_bit(1, 40, n);
        check("ch1_div0_bit_second", n, 16);

        // restart written on the terminal-count cycle
        wr(1'b1, ADDR_DIVLO, 8'h07);
        wr(1'b1, ADDR_DIVHI, 8'h00);
        wait_tick(1, 20, n);
        check("ch1_div7_first", n, 7);
        repeat (6) @(posedge clk);
        #1;
        wr(1'b1, ADDR_CTRL, 8'h03);
        check("restart_suppresses_tick", int'(sample_tick[1]), 0);
        wait_tick(1, 20, n);
        check("restart_next_tick", n, 7);

        // disable ch1
        wr(1'b1, ADDR_CTRL, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        s1 = tc1;
        repeat (30) @(posedge clk);
        #1;
        check("ch1_disabled_no_tick", tc1 - s1, 0);
        check("ch1_disabled_bit", int'(bit_tick[1]), 0);

        // unqualified writes change nothing
        iocs = 1'b0; iowr = 1'b1; ch_sel = 1'b1; ioaddr = ADDR_CTRL; wdata = 8'h01;
        @(posedge clk); #1;
        iocs = 1'b1; iowr = 1'b0;
        @(posedge clk); #1;
        iocs = 1'b0;
        s1 = tc1;
        repeat (30) @(posedge clk);
        #1;
        check("no_write_without_qualify", tc1 - s1, 0);

        // reset mid-count, overriding a simultaneous enable write to ch1
        wr(1'b1, ADDR_CTRL, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; iocs = 1'b1; iowr = 1'b1; ch_sel = 1'b1; ioaddr = ADDR_CTRL; wdata = 8'h01;
        @(posedge clk); #1;
        check("rst_sample_tick", int'(sample_tick), 0);
        check("rst_bit_tick", int'(bit_tick), 0);
        rst = 1'b0; iocs = 1'b0; iowr = 1'b0;
        s0 = tc0;
        s1 = tc1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_beats_write", tc1 - s1, 0);
        wr(1'b1, ADDR_CTRL, 8'h01);
        wait_tick(1, 400, n);
        check("rst_div_restored", n, 325);
        check("ch0_disabled_after_rst", tc0 - s0, 0);

        // fractional divider: D=10, F=8
        wr(1'b1, ADDR_DIVLO, 8'h0a);
        wr(1'b1, ADDR_FRAC, 8'h08);
        wr(1'b1, ADDR_DIVHI, 8'h00);
        e1 = cyc;
        wait_tick(1, 30, n);
        check("frac_period_1", n, 10);
        wait_tick(1, 30, n);
`ifdef BAUD_GEN_FRAC_EN
        check("frac_period_2", n, 11);
`else
        check("frac_period_2", n, 10);
`endif
        k = 0;
        for (int i = 0; i < 14; i++) begin
            wait_tick(1, 30, n);
            if (n < 0) k = 1;
        end
`ifdef BAUD_GEN_FRAC_EN
        check("frac_16_periods", (k != 0) ? -1 : cyc - e1, 168);
`else
        check("frac_16_periods", (k != 0) ? -1 : cyc - e1, 160);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
